// File: rtl/fp_mult_pipe.sv
// Purpose : parametrised 3-stage pipelined floating-point multiplier (sign/exp/man), RNE or truncate.
// Latency : 3 enabled cycles from accept to oValid; throughput 1/cycle while iReady stays high.
// Backpr. : whole pipe stalls (no bubble collapse) while oValid & !iReady; oReady = !oValid | iReady.
//
// Ports:
//   iClk, iRstN        clock (rising edge), asynchronous active-low reset
//   iValid / oReady    input handshake; operands iDataA/iDataB, rounding mode iRound, side-band iTag
//   oValid / iReady    output handshake; product oData, returned tag oTag
//   oFlags             {invalid, overflow, underflow}, aligned with oData
// Subnormal operands are flushed to zero. MAN_W must be at least 2.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [W-1:0]     iDataA,
  input  logic [W-1:0]     iDataB,
  input  logic             iRound,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [W-1:0]     oData,
  output logic [TAG_W-1:0] oTag,
  output logic [2:0]       oFlags
);

  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int ES_W    = EXP_W + 2;          // signed exponent sum, covers both under- and overflow
  localparam int PW      = 2 * (MAN_W + 1);    // full significand product width

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  // Pipeline enable: every stage advances together, or nothing moves.
  logic w_en;
  assign w_en   = !oValid | iReady;
  assign oReady = w_en;

  // ---------------- Stage 1: unpack, classify, exponent sum, significand product
  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [MAN_W-1:0] w_man_a, w_man_b;
  cls_t             w_cls_a, w_cls_b;
  logic [ES_W-1:0]  w_esum;
  logic [PW-1:0]    w_prod;

  assign w_exp_a = iDataA[W-2 -: EXP_W];
  assign w_exp_b = iDataB[W-2 -: EXP_W];
  assign w_man_a = iDataA[MAN_W-1:0];
  assign w_man_b = iDataB[MAN_W-1:0];

  assign w_cls_a.zero = (w_exp_a == '0);
  assign w_cls_a.inf  = (&w_exp_a) & (w_man_a == '0);
  assign w_cls_a.nan  = (&w_exp_a) & (w_man_a != '0);
  assign w_cls_b.zero = (w_exp_b == '0);
  assign w_cls_b.inf  = (&w_exp_b) & (w_man_b == '0);
  assign w_cls_b.nan  = (&w_exp_b) & (w_man_b != '0);

  // Two's-complement bit pattern; interpreted as signed from stage 2 on.
  assign w_esum = ES_W'({2'b00, w_exp_a}) + ES_W'({2'b00, w_exp_b}) - ES_W'(BIAS);
  assign w_prod = PW'({1'b1, w_man_a}) * PW'({1'b1, w_man_b});

  logic             r_s1_vld;
  logic             r_s1_sign;
  logic [ES_W-1:0]  r_s1_esum;
  logic [PW-1:0]    r_s1_prod;
  cls_t             r_s1_cls_a, r_s1_cls_b;
  logic             r_s1_round;
  logic [TAG_W-1:0] r_s1_tag;

  // ---------------- Stage 2: normalise and round
  // Product of two [1,2) significands lies in [1,4); a set MSB means one extra exponent step.
  logic [PW-1:0]    w_norm;
  logic [MAN_W-1:0] w_frac;
  logic             w_guard, w_sticky, w_inc;
  logic [MAN_W:0]   w_frac_rnd;
  logic [ES_W-1:0]  w_esum2;

  assign w_norm     = r_s1_prod[PW-1] ? r_s1_prod : {r_s1_prod[PW-2:0], 1'b0};
  assign w_frac     = w_norm[PW-2 -: MAN_W];
  assign w_guard    = w_norm[PW-2-MAN_W];
  assign w_sticky   = |w_norm[PW-3-MAN_W:0];
  assign w_inc      = r_s1_round & w_guard & (w_sticky | w_frac[0]);
  assign w_frac_rnd = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
  // A rounding carry-out turns 1.11..1 into 10.00..0: fraction bits are already zero,
  // only the exponent needs the extra step.
  assign w_esum2    = r_s1_esum + ES_W'(r_s1_prod[PW-1]) + ES_W'(w_frac_rnd[MAN_W]);

  logic                   r_s2_vld;
  logic                   r_s2_sign;
  logic signed [ES_W-1:0] r_s2_esum;
  logic [MAN_W-1:0]       r_s2_frac;
  cls_t                   r_s2_cls_a, r_s2_cls_b;
  logic [TAG_W-1:0]       r_s2_tag;

  // ---------------- Stage 3: exceptions and pack (priority order matters)
  logic [W-1:0] w_res_dat;
  logic [2:0]   w_res_flg;
  logic         w_ovf, w_unf;

  assign w_ovf = (r_s2_esum >= $signed(ES_W'(EXP_MAX)));
  assign w_unf = (r_s2_esum <= $signed(ES_W'(0)));

  always_comb begin
    w_res_dat = '0;
    w_res_flg = 3'b000;
    if (r_s2_cls_a.nan | r_s2_cls_b.nan) begin
      w_res_dat = QNAN;
    end else if ((r_s2_cls_a.inf & r_s2_cls_b.zero) | (r_s2_cls_a.zero & r_s2_cls_b.inf)) begin
      w_res_dat = QNAN;
      w_res_flg = 3'b100;
    end else if (r_s2_cls_a.inf | r_s2_cls_b.inf) begin
      w_res_dat = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (r_s2_cls_a.zero | r_s2_cls_b.zero) begin
      w_res_dat = {r_s2_sign, {(W-1){1'b0}}};
    end else if (w_ovf) begin
      w_res_dat = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_res_flg = 3'b010;
    end else if (w_unf) begin
      w_res_dat = {r_s2_sign, {(W-1){1'b0}}};
      w_res_flg = 3'b001;
    end else begin
      w_res_dat = {r_s2_sign, r_s2_esum[EXP_W-1:0], r_s2_frac};
    end
  end

  // ---------------- Pipeline registers
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_s1_vld   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_esum  <= '0;
      r_s1_prod  <= '0;
      r_s1_cls_a <= '0;
      r_s1_cls_b <= '0;
      r_s1_round <= 1'b0;
      r_s1_tag   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_esum  <= '0;
      r_s2_frac  <= '0;
      r_s2_cls_a <= '0;
      r_s2_cls_b <= '0;
      r_s2_tag   <= '0;
      oValid     <= 1'b0;
      oData      <= '0;
      oTag       <= '0;
      oFlags     <= 3'b000;
    end else if (w_en) begin
      r_s1_vld   <= iValid;
      r_s1_sign  <= iDataA[W-1] ^ iDataB[W-1];
      r_s1_esum  <= w_esum;
      r_s1_prod  <= w_prod;
      r_s1_cls_a <= w_cls_a;
      r_s1_cls_b <= w_cls_b;
      r_s1_round <= iRound;
      r_s1_tag   <= iTag;

      r_s2_vld   <= r_s1_vld;
      r_s2_sign  <= r_s1_sign;
      r_s2_esum  <= w_esum2;
      r_s2_frac  <= w_frac_rnd[MAN_W-1:0];
      r_s2_cls_a <= r_s1_cls_a;
      r_s2_cls_b <= r_s1_cls_b;
      r_s2_tag   <= r_s1_tag;

      oValid     <= r_s2_vld;
      // Bubbles leave the last result on the bus rather than pipeline garbage.
      if (r_s2_vld) begin
        oData  <= w_res_dat;
        oTag   <= r_s2_tag;
        oFlags <= w_res_flg;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
module tb_fp_mult_pipe;

  logic        iClk;
  logic        iRstN;
  logic        iValid;
  logic        oReady;
  logic [15:0] iDataA;
  logic [15:0] iDataB;
  logic        iRound;
  logic [3:0]  iTag;
  logic        oValid;
  logic        iReady;
  logic [15:0] oData;
  logic [3:0]  oTag;
  logic [2:0]  oFlags;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iValid (iValid),
    .oReady (oReady),
    .iDataA (iDataA),
    .iDataB (iDataB),
    .iRound (iRound),
    .iTag   (iTag),
    .oValid (oValid),
    .iReady (iReady),
    .oData  (oData),
    .oTag   (oTag),
    .oFlags (oFlags)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rnd;
    logic [15:0] dat;
    logic [2:0]  flg;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op with iReady held high, then wait for its result and check it.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic rnd, input logic [3:0] tag,
                        input logic [15:0] dat, input logic [2:0] flg);
    int cyc;
    iValid = 1'b1; iDataA = a; iDataB = b; iRound = rnd; iTag = tag; iReady = 1'b1;
    #1;
    chk({name, "_ordy"}, 32'(oReady), 32'd1);
    @(posedge iClk); #1;
    iValid = 1'b0;
    cyc = 1;
    while (!oValid && cyc < 10) begin
      @(posedge iClk); #1;
      cyc++;
    end
    chk({name, "_lat"}, 32'(cyc), 32'd3);
    chk({name, "_dat"}, 32'(oData), 32'(dat));
    chk({name, "_flg"}, 32'(oFlags), 32'(flg));
    chk({name, "_tag"}, 32'(oTag), 32'(tag));
  endtask

  initial begin
    int ni, no, stall, cyc;
    logic seen_first;
    logic [15:0] held;

    //          a         b         rnd   result    flags
    vec[0]  = '{16'h3FC0, 16'h4000, 1'b0, 16'h4040, 3'b000}; // 1.5 * 2
    vec[1]  = '{16'h3FC1, 16'h3FC1, 1'b0, 16'h4011, 3'b000}; // truncate
    vec[2]  = '{16'h3FC1, 16'h3FC1, 1'b1, 16'h4012, 3'b000}; // RNE rounds up
    vec[3]  = '{16'h7F00, 16'h4000, 1'b0, 16'h7F80, 3'b010}; // overflow
    vec[4]  = '{16'h0080, 16'h3F00, 1'b0, 16'h0000, 3'b001}; // underflow (esum == 0)
    vec[5]  = '{16'hC000, 16'h0000, 1'b0, 16'h8000, 3'b000}; // signed zero
    vec[6]  = '{16'h7F80, 16'h0000, 1'b0, 16'h7FC0, 3'b100}; // inf * 0
    vec[7]  = '{16'h7FC5, 16'h3F80, 1'b0, 16'h7FC0, 3'b000}; // NaN in
    vec[8]  = '{16'hFF80, 16'h4000, 1'b0, 16'hFF80, 3'b000}; // -inf
    vec[9]  = '{16'h3FB5, 16'h3FB5, 1'b1, 16'h4000, 3'b000}; // rounding carry-out
    vec[10] = '{16'h3FB5, 16'h3FB5, 1'b0, 16'h3FFF, 3'b000}; // same, truncate
    vec[11] = '{16'h3FC0, 16'h3FAE, 1'b1, 16'h4002, 3'b000}; // tie, even lsb: no inc
    vec[12] = '{16'h3FC0, 16'h3FB2, 1'b1, 16'h4006, 3'b000}; // tie, odd lsb: inc
    vec[13] = '{16'h3FC0, 16'h3FB2, 1'b0, 16'h4005, 3'b000}; // same, truncate
    vec[14] = '{16'h8000, 16'h0080, 1'b0, 16'h8000, 3'b000}; // zero never underflows
    vec[15] = '{16'hBFC0, 16'h4000, 1'b0, 16'hC040, 3'b000}; // negative normal

    iRstN = 1'b0; iValid = 1'b0; iDataA = '0; iDataB = '0; iRound = 1'b0; iTag = '0; iReady = 1'b1;
    #12;
    chk("rst_ovld", 32'(oValid), 32'd0);
    chk("rst_odat", 32'(oData), 32'd0);
    chk("rst_otag", 32'(oTag), 32'd0);
    chk("rst_oflg", 32'(oFlags), 32'd0);
    chk("rst_ordy", 32'(oReady), 32'd1);
    #11;
    iRstN = 1'b1;
    @(posedge iClk); #1;

    // Table-driven single ops.
    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), vec[i].a, vec[i].b, vec[i].rnd, 4'(i), vec[i].dat, vec[i].flg);
    @(posedge iClk); #1;

    // Back-pressure: 6 ops streamed back to back, iReady dropped 4 cycles at the first result.
    ni = 0; no = 0; stall = 0; cyc = 0; seen_first = 1'b0; held = '0;
    while (no < 6 && cyc < 100) begin
      if (ni < 6) begin
        iValid = 1'b1; iDataA = vec[ni].a; iDataB = vec[ni].b; iRound = vec[ni].rnd; iTag = 4'(ni);
      end else begin
        iValid = 1'b0;
      end
      if (oValid && !seen_first) begin
        seen_first = 1'b1;
        stall = 4;
        held = oData;
      end
      iReady = (stall == 0);
      if (stall > 0) stall--;
      #1;
      if (!iReady) begin
        chk($sformatf("bp_ordy_c%0d", cyc), 32'(oReady), 32'd0);
        chk($sformatf("bp_hold_c%0d", cyc), 32'(oData), 32'(held));
      end
      if (oValid && iReady) begin
        chk($sformatf("bp_tag%0d", no), 32'(oTag), 32'(no));
        chk($sformatf("bp_dat%0d", no), 32'(oData), 32'(vec[no].dat));
        chk($sformatf("bp_flg%0d", no), 32'(oFlags), 32'(vec[no].flg));
        no++;
      end
      if (iValid && oReady) ni++;
      @(posedge iClk); #1;
      cyc++;
    end
    chk("bp_count", 32'(no), 32'd6);
    iValid = 1'b0; iReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_nodup%0d", i), 32'(oValid), 32'd0);
      @(posedge iClk); #1;
    end

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      iValid = 1'b1; iDataA = 16'h3FC0; iDataB = 16'h4000; iRound = 1'b0; iTag = 4'(i + 1);
      @(posedge iClk); #1;
    end
    iValid = 1'b0;
    #1;
    chk("mid_pre_ovld", 32'(oValid), 32'd1);
    iRstN = 1'b0;
    #1;
    chk("mid_rst_ovld", 32'(oValid), 32'd0);
    chk("mid_rst_odat", 32'(oData), 32'd0);
    chk("mid_rst_otag", 32'(oTag), 32'd0);
    @(posedge iClk); #3;
    iRstN = 1'b1;
    @(posedge iClk); #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_stale%0d", i), 32'(oValid), 32'd0);
      @(posedge iClk); #1;
    end
    run_op("post_rst", 16'hBFC0, 16'h4000, 1'b0, 4'd9, 16'hC040, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, 3-stage pipelined floating-point multiplier with valid/ready handshake.
- Generalises the team's single-cycle bfloat16 multiplier:
  - configurable exponent/mantissa widths;
  - per-operation rounding mode (truncate or round-to-nearest-even);
  - exception flags;
  - tag pass-through;
  - back-pressure.
- Sits between operand-issue logic and MAC/accumulator blocks in the compute datapath.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 7, stored mantissa field width (hidden bit implicit).
- TAG_W, 4, width of the side-band tag carried alongside each operation.
- W = 1+EXP_W+MAN_W (derived, not overridable).

Ports:
- iClk  in  1  clock, rising edge.
- iRstN  in  1  reset, asynchronous, active-low.
- iValid  in  1  input operation valid.
- oReady  out  1  block can accept an input this cycle.
- iDataA  in  W  operand A {sign, exp, man}.
- iDataB  in  W  operand B.
- iRound  in  1  0 = truncate, 1 = round-to-nearest-even (RNE).
- iTag  in  TAG_W  user tag, returned unchanged with the result.
- oValid  out  1  result valid.
- iReady  in  1  downstream accepts result.
- oData  out  W  product.
- oTag  out  TAG_W  tag of the result.
- oFlags  out  3  {invalid, overflow, underflow}, aligned with oData.

Behaviour:
- Reset (iRstN low, async): all stage valids = 0; oValid = 0, oData = 0, oTag = 0, oFlags = 0. Reset asserted mid-operation discards all in-flight operations.
- Pipeline enable: en = !oValid | iReady; oReady = en (combinational).
  - Input accepted when iValid & oReady.
  - When en = 0 all stages hold (no bubble collapse).
- Latency: exactly 3 cycles of en = 1 from accept to oValid. Throughput 1/cycle when iReady is held high.
- Output stability: oData/oTag/oFlags are held stable while oValid & !iReady.
- S1 (accept edge):
  - register sign = sA^sB;
  - esum = eA + eB - BIAS as signed (EXP_W+2)-bit;
  - product of {1,manA}*{1,manB}, 2*(MAN_W+1) bits;
  - class bits (zero, inf, nan) per operand;
  - iRound, iTag.
- Operand classification:
  - exp = 0 -> zero (subnormals flushed to zero);
  - exp all-ones with man = 0 -> Inf;
  - exp all-ones with man != 0 -> NaN.
- S2 normalise and round:
  - If product MSB = 1: shift right 1, esum += 1.
  - Keep MAN_W fraction bits; guard = next bit; sticky = OR of the remaining bits.
  - RNE: increment if guard & (sticky | lsb).
  - Truncate: no increment.
  - Rounding carry-out renormalises the significand and increments esum.
- S3 exception and pack, in priority order:
  1. Any NaN operand -> canonical NaN {0, all-ones, 1, zeros}; invalid = 0.
  2. Inf × zero -> canonical NaN; invalid = 1.
  3. Either operand Inf -> {sign, Inf}.
  4. Either operand zero -> {sign, 0}.
  5. esum >= 2^EXP_W-1 -> {sign, Inf}; overflow = 1.
  6. esum <= 0 -> {sign, 0}; underflow = 1.
  7. Otherwise -> {sign, esum[EXP_W-1:0], fraction}.
- Flags: at most one flag set per result; zero operands never raise underflow.
- Sign is preserved on zero and Inf results.
- Simultaneous events: an accept and a drain in the same cycle are legal.
- iValid & !oReady: the input is not captured; the source holds it.

Test Plan:
- Basic multiply: A = 0x3FC0 (1.5), B = 0x4000 (2.0), iRound = 0, iTag = 5 -> after 3 cycles oValid = 1, oData = 0x4040, oTag = 5, oFlags = 0.
- Rounding mode: A = B = 0x3FC1, iRound = 0 -> 0x4011; same operands with iRound = 1 -> 0x4012; both have flags = 0.
- Overflow/underflow:
  - 0x7F00 × 0x4000 -> 0x7F80, flags = 3'b010.
  - 0x0080 × 0x3F00 -> 0x0000, flags = 3'b001.
  - 0xC000 × 0x0000 -> 0x8000, flags = 0.
- Specials:
  - 0x7F80 × 0x0000 -> 0x7FC0, flags = 3'b100.
  - 0x7FC5 × 0x3F80 -> 0x7FC0, flags = 0.
  - 0xFF80 × 0x4000 -> 0xFF80, flags = 0.
- Back-pressure: stream 6 ops with tags 0..5 and drop iReady for 4 cycles after the first result -> oReady = 0 during the stall, oData held stable, no loss or duplication; tags exit in order 0..5 and results match single-op references.
- Reset mid-stream: assert iRstN low with 3 ops in flight -> oValid = 0 and oData = 0 immediately (async); after release, the first new op appears exactly 3 cycles after acceptance and no stale results are emitted.
